// File: rtl/uart_rx_ctrl.sv
// UART receiver: oversampled start detection, LSB-first data, optional parity,
// one or two stop bits, break detection on an all-zero frame.
module uart_rx_ctrl #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 sample_tick,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 pend_perr, pend_ferr, stop_one;
    logic                 bit_hit, last_data, last_stop, frame_done, frame_bad, is_break;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY_MODE == 2) ? ~(^d) : (^d);
    endfunction

    // bit_hit marks the tick on which the current bit is sampled
    always_comb begin
        bit_hit = 1'b0;
        if (sample_tick) begin
            case (state)
                S_START:                  bit_hit = (cnt == HALF_LAST);
                S_DATA, S_PARITY, S_STOP: bit_hit = (cnt == FULL_LAST);
                default:                  bit_hit = 1'b0;
            endcase
        end
    end

    assign last_data  = (bit_cnt == DATA_LAST);
    assign last_stop  = (bit_cnt == STOP_LAST);
    assign frame_done = bit_hit && (state == S_STOP) && last_stop;
    assign frame_bad  = pend_ferr | ~rx;
    assign is_break   = (shreg == '0) && !stop_one && !rx;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (sample_tick && !rx) state_nxt = S_START;
            S_START:  if (bit_hit) state_nxt = rx ? S_IDLE : S_DATA;
            S_DATA:   if (bit_hit && last_data) state_nxt = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (bit_hit) state_nxt = S_STOP;
            S_STOP:   if (frame_done) state_nxt = (frame_bad && is_break) ? S_BREAK : S_IDLE;
            S_BREAK:  if (sample_tick && rx) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            pend_perr  <= 1'b0;
            pend_ferr  <= 1'b0;
            stop_one   <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid <= frame_done;

            if (state == S_IDLE || state == S_BREAK) cnt <= '0;
            else if (sample_tick)                   cnt <= bit_hit ? '0 : cnt + 1'b1;

            if (bit_hit) begin
                case (state)
                    S_START: begin
                        bit_cnt   <= '0;
                        pend_perr <= 1'b0;
                        pend_ferr <= 1'b0;
                        stop_one  <= 1'b0;
                    end
                    S_DATA: begin
                        shreg   <= {rx, shreg[DATA_BITS-1:1]};
                        bit_cnt <= last_data ? '0 : bit_cnt + 1'b1;
                    end
                    S_PARITY: pend_perr <= (rx != parity_of(shreg));
                    S_STOP: begin
                        bit_cnt <= last_stop ? '0 : bit_cnt + 1'b1;
                        if (!rx) pend_ferr <= 1'b1;
                        else     stop_one  <= 1'b1;
                    end
                    default: ;
                endcase
            end

            // Result registers change only when a frame is delivered
            if (frame_done) begin
                rx_data    <= shreg;
                parity_err <= pend_perr;
                frame_err  <= frame_bad;
            end
        end
    end

    assign break_det = (state == S_BREAK);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus randomized frames checked
// against a frame-level model of the expected result word.
module tb_uart_rx_ctrl;
    localparam int DATA_BITS   = 8;
    localparam int OVERSAMPLE  = 16;
    localparam int PARITY_MODE = 1;
    localparam int STOP_BITS   = 1;

    logic                 clk = 1'b0;
    logic                 rst_n, rx, sample_tick;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid, parity_err, frame_err, break_det, busy;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    int div = 1;
    logic [10:0] got_q[$];

    always #5 clk = ~clk;

    uart_rx_ctrl #(
        .DATA_BITS(DATA_BITS), .OVERSAMPLE(OVERSAMPLE),
        .PARITY_MODE(PARITY_MODE), .STOP_BITS(STOP_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .sample_tick(sample_tick),
        .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
        .frame_err(frame_err), .break_det(break_det), .busy(busy)
    );

    // Every cycle with rx_valid high records one delivered result word
    always @(negedge clk) if (rx_valid) got_q.push_back({frame_err, parity_err, rx_data});

    initial begin
        #900000;
        $display("FAIL watchdog: observed no finish, expected finish before 900us");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_next(input string tag, input logic [10:0] exp);
        logic [10:0] g;
        check({tag, "_present"}, (got_q.size() != 0), 1);
        if (got_q.size() != 0) begin
            g = got_q.pop_front();
            check({tag, "_data"}, g[7:0], exp[7:0]);
            check({tag, "_perr"}, g[8], exp[8]);
            check({tag, "_ferr"}, g[9], exp[9]);
        end
    endtask

    // Expected {frame_err, parity_err, data} from the bits placed on the line
    function automatic logic [10:0] model_frame(input logic [7:0] data, input logic pbit,
                                                input logic stopb);
        int   ones;
        logic want_p;
        logic perr;
        ones = 0;
        for (int i = 0; i < 8; i++) if (data[i]) ones++;
        want_p = (PARITY_MODE == 2) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        perr   = (PARITY_MODE != 0) && (pbit != want_p);
        return {~stopb, perr, data};
    endfunction

    task automatic do_tick();
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (div - 1) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (OVERSAMPLE) do_tick();
    endtask

    task automatic send_frame(input logic [7:0] data, input logic pbit, input logic stopb);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(pbit);
        send_bit(stopb);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) do_tick();
    endtask

    initial begin
        logic [7:0]  d;
        logic        pb, sb;
        logic [10:0] exp;

        rst_n = 1'b0; rx = 1'b1; sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", rx_data, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_break", break_det, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        idle(4);

        // Clean frame, correct even parity
        div = 1;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(4);
        check("a5_count", got_q.size(), 1);
        check_next("a5_ok", model_frame(8'hA5, 1'b0, 1'b1));
        check("a5_busy_after", busy, 0);

        // Wrong parity bit
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(4);
        check("a5p_count", got_q.size(), 1);
        exp = model_frame(8'hA5, 1'b1, 1'b1);
        check_next("a5_perr", exp);
        idle(10);
        check("hold_data", rx_data, exp[7:0]);
        check("hold_perr", parity_err, exp[8]);

        // Glitch shorter than half a bit
        rx = 1'b0;
        repeat (4) do_tick();
        check("fs_busy_mid", busy, 1);
        rx = 1'b1;
        repeat (5) do_tick();
        check("fs_busy_end", busy, 0);
        idle(8);
        check("fs_no_valid", got_q.size(), 0);

        // Line held low for three frame times
        rx = 1'b0;
        repeat (3 * 11 * OVERSAMPLE) do_tick();
        check("brk_count", got_q.size(), 1);
        check_next("brk", model_frame(8'h00, 1'b0, 1'b0));
        check("brk_det_high", break_det, 1);
        check("brk_busy_high", busy, 1);
        rx = 1'b1;
        do_tick();
        check("brk_det_low", break_det, 0);
        check("brk_busy_low", busy, 0);
        idle(4);

        // Back-to-back frames, tick every third cycle
        div = 3;
        send_frame(8'h3C, 1'b0, 1'b1);
        send_frame(8'hC3, 1'b0, 1'b1);
        idle(4);
        check("b2b_count", got_q.size(), 2);
        check_next("b2b_first", model_frame(8'h3C, 1'b0, 1'b1));
        check_next("b2b_second", model_frame(8'hC3, 1'b0, 1'b1));

        // Asynchronous reset in the middle of data bit 4
        div = 1;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx = 1'b0;
        repeat (5) do_tick();
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_data", rx_data, 0);
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_perr", parity_err, 0);
        check("mid_rst_ferr", frame_err, 0);
        check("mid_rst_break", break_det, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        check("post_rst_no_valid", got_q.size(), 0);
        send_frame(8'h5A, 1'b0, 1'b1);
        idle(4);
        check("post_rst_count", got_q.size(), 1);
        check_next("post_rst_5a", model_frame(8'h5A, 1'b0, 1'b1));

        // Randomized frames, tick spacing and error injection
        for (int k = 0; k < 12; k++) begin
            div = int'($urandom_range(1, 4));
            d   = 8'($urandom);
            pb  = 1'($urandom_range(0, 1));
            sb  = ($urandom_range(0, 4) != 0);
            send_frame(d, pb, sb);
            idle(2 * OVERSAMPLE);
            check($sformatf("rnd%0d_count", k), got_q.size(), 1);
            check_next($sformatf("rnd%0d", k), model_frame(d, pb, sb));
            got_q.delete();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
